ik_pos_err: RTL

- Sits directly downstream of the forward-kinematics matrix stage and consumes its translation column: full_matrix rows 0-2, column 3.
- Compares the end-effector position against the target position written over the bus.
- Produces the per-axis error vector, the squared error norm and a converged flag for the IK iteration controller.
- Uses one shared multiplier, sequenced by a small FSM.

---
 rtl/ik_pos_err.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/ik_pos_err.sv
// Position-error stage for the IK loop: per-axis error, squared norm via one shared multiplier, convergence flag.
// Optional build macro IK_POS_ERR_STATS_EN adds a saturating completed-evaluation counter on eval_count.
module ik_pos_err #(
  parameter int W         = 27,
  parameter int FRAC_BITS = 16,
  parameter int SQ_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mat_valid,
  input  logic signed [W-1:0] pos_x,
  input  logic signed [W-1:0] pos_y,
  input  logic signed [W-1:0] pos_z,
  input  logic signed [W-1:0] tgt_x,
  input  logic signed [W-1:0] tgt_y,
  input  logic signed [W-1:0] tgt_z,
  input  logic [SQ_W-1:0]     tol_sq,
  output logic                busy,
  output logic                done,
  output logic signed [W:0]   err_x,
  output logic signed [W:0]   err_y,
  output logic signed [W:0]   err_z,
  output logic [SQ_W-1:0]     err_sq,
  output logic                converged,
  output logic [15:0]         eval_count
);

  localparam int ACC_W = SQ_W + 10;
  localparam int PW    = 2 * (W + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_SUB  = 3'd2,
    S_SQ   = 3'd3,
    S_CMP  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t state_r, state_s;

  logic signed [W-1:0] pos_x_r, pos_y_r, pos_z_r;
  logic signed [W-1:0] tgt_x_r, tgt_y_r, tgt_z_r;
  logic signed [W:0]   err_x_r, err_y_r, err_z_r;
  logic signed [W:0]   sub_x_s, sub_y_s, sub_z_s;
  logic signed [W:0]   sel_err_s;
  logic [W:0]          mag_s;
  logic [PW-1:0]       prod_s;
  logic [ACC_W-1:0]    add_s;
  logic [ACC_W-1:0]    acc_r;
  logic [1:0]          axis_r;
  logic [SQ_W-1:0]     err_sq_r, sat_s;
  logic                converged_r;
  logic                busy_r, done_r;

  logic capture_s, load_err_s, sq_step_s, load_cmp_s, busy_nxt_s, done_nxt_s;

  // Clamp the wide accumulator into the SQ_W-bit result range.
  function automatic logic [SQ_W-1:0] sat_sq(input logic [ACC_W-1:0] a);
    if (|a[ACC_W-1:SQ_W]) begin
      return {SQ_W{1'b1}};
    end else begin
      return a[SQ_W-1:0];
    end
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start outside IDLE is deliberately ignored
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start && mat_valid) begin
          state_s = S_SUB;
        end else if (start) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mat_valid) begin
          state_s = S_SUB;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_SUB:  state_s = S_SQ;
      S_SQ: begin
        if (axis_r == 2'd2) begin
          state_s = S_CMP;
        end else begin
          state_s = S_SQ;
        end
      end
      S_CMP:  state_s = S_DONE;
      S_DONE: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    capture_s  = 1'b0;
    load_err_s = 1'b0;
    sq_step_s  = 1'b0;
    load_cmp_s = 1'b0;
    case (state_r)
      S_IDLE:  capture_s  = start & mat_valid;
      S_WAIT:  capture_s  = mat_valid;
      S_SUB:   load_err_s = 1'b1;
      S_SQ:    sq_step_s  = 1'b1;
      S_CMP:   load_cmp_s = 1'b1;
      S_DONE:  capture_s  = 1'b0;
      default: capture_s  = 1'b0;
    endcase
    busy_nxt_s = (state_s != S_IDLE);
    done_nxt_s = (state_s == S_DONE);
  end

  // Errors are formed one bit wider than the inputs so the difference cannot wrap.
  assign sub_x_s = {tgt_x_r[W-1], tgt_x_r} - {pos_x_r[W-1], pos_x_r};
  assign sub_y_s = {tgt_y_r[W-1], tgt_y_r} - {pos_y_r[W-1], pos_y_r};
  assign sub_z_s = {tgt_z_r[W-1], tgt_z_r} - {pos_z_r[W-1], pos_z_r};

  // Shared squarer: select axis, take magnitude, square, drop fraction bits
  always_comb begin
    case (axis_r)
      2'd0:    sel_err_s = err_x_r;
      2'd1:    sel_err_s = err_y_r;
      2'd2:    sel_err_s = err_z_r;
      default: sel_err_s = {(W+1){1'b0}};
    endcase
    if (sel_err_s[W]) begin
      mag_s = $unsigned(-sel_err_s);
    end else begin
      mag_s = $unsigned(sel_err_s);
    end
    prod_s = {{(W+1){1'b0}}, mag_s} * {{(W+1){1'b0}}, mag_s};
    add_s  = ACC_W'(prod_s >> FRAC_BITS);
    sat_s  = sat_sq(acc_r);
  end

  // Input capture and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x_r     <= {W{1'b0}};
      pos_y_r     <= {W{1'b0}};
      pos_z_r     <= {W{1'b0}};
      tgt_x_r     <= {W{1'b0}};
      tgt_y_r     <= {W{1'b0}};
      tgt_z_r     <= {W{1'b0}};
      err_x_r     <= {(W+1){1'b0}};
      err_y_r     <= {(W+1){1'b0}};
      err_z_r     <= {(W+1){1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      axis_r      <= 2'd0;
      err_sq_r    <= {SQ_W{1'b0}};
      converged_r <= 1'b0;
    end else begin
      if (capture_s) begin
        pos_x_r <= pos_x;
        pos_y_r <= pos_y;
        pos_z_r <= pos_z;
        tgt_x_r <= tgt_x;
        tgt_y_r <= tgt_y;
        tgt_z_r <= tgt_z;
      end
      if (load_err_s) begin
        err_x_r <= sub_x_s;
        err_y_r <= sub_y_s;
        err_z_r <= sub_z_s;
        acc_r   <= {ACC_W{1'b0}};
        axis_r  <= 2'd0;
      end else if (sq_step_s) begin
        acc_r  <= acc_r + add_s;
        axis_r <= axis_r + 2'd1;
      end
      // tol_sq is sampled live here, not at capture
      if (load_cmp_s) begin
        err_sq_r    <= sat_s;
        converged_r <= (sat_s <= tol_sq);
      end
    end
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

`ifdef IK_POS_ERR_STATS_EN
  logic [15:0] eval_count_r;

  // Saturating completed-evaluation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      eval_count_r <= 16'h0000;
    end else if ((state_r == S_DONE) && (eval_count_r != 16'hFFFF)) begin
      eval_count_r <= eval_count_r + 16'h0001;
    end else begin
      eval_count_r <= eval_count_r;
    end
  end

  assign eval_count = eval_count_r;
`else
  assign eval_count = 16'h0000;
`endif

  assign busy      = busy_r;
  assign done      = done_r;
  assign err_x     = err_x_r;
  assign err_y     = err_y_r;
  assign err_z     = err_z_r;
  assign err_sq    = err_sq_r;
  assign converged = converged_r;

endmodule
